// File: rtl/id_ex_forward_stage_if.sv
// ID/EX stage bundle: decoded ID operands in, registered EX operands, forwarding selects and stall out.
// The pipeline controller (master) drives ID and writeback-stage info; the stage (slave) answers.
interface id_ex_forward_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dest;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [3:0]        id_alu_ctrl;
    logic              flush;
    logic [REG_AW-1:0] exmem_dest;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] memwb_dest;
    logic              memwb_reg_write;

    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dest;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [3:0]        ex_alu_ctrl;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic [31:0]       stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_rd1, id_rd2, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_ctrl, flush,
               exmem_dest, exmem_reg_write, memwb_dest, memwb_reg_write,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rs, ex_rt,
               ex_dest, ex_rd1, ex_rd2, ex_imm, ex_alu_ctrl, fwd_a_sel, fwd_b_sel,
               stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_rd1, id_rd2, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_ctrl, flush,
               exmem_dest, exmem_reg_write, memwb_dest, memwb_reg_write,
        output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rs, ex_rt,
               ex_dest, ex_rd1, ex_rd2, ex_imm, ex_alu_ctrl, fwd_a_sel, fwd_b_sel,
               stall, stall_count
    );
endinterface

// File: rtl/id_ex_forward_stage.sv
// MIPS ID/EX pipeline register with EX operand forwarding selects and load-use stall detection.
// A flush or a load-use stall loads a bubble (all zeros) into EX instead of the ID instruction.
module id_ex_forward_stage (
    input logic                  clk,
    input logic                  rst_n,
    id_ex_forward_stage_if.slave bus
);
    logic        bubble;
    logic [31:0] stall_cnt;

    // A flushed ID instruction is squashed anyway, so it must never cause a stall.
    assign bus.stall = bus.ex_valid & bus.ex_mem_read & (bus.ex_dest != '0) &
                       bus.id_valid & ~bus.flush &
                       ((bus.ex_dest == bus.id_rs) | (bus.ex_dest == bus.id_rt));
    assign bubble          = bus.flush | bus.stall;
    assign bus.stall_count = stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_ctrl  <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_dest      <= '0;
            bus.ex_rd1       <= '0;
            bus.ex_rd2       <= '0;
            bus.ex_imm       <= '0;
        end else if (bubble) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_ctrl  <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_dest      <= '0;
            bus.ex_rd1       <= '0;
            bus.ex_rd2       <= '0;
            bus.ex_imm       <= '0;
        end else begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_reg_write <= bus.id_reg_write;
            bus.ex_mem_read  <= bus.id_mem_read;
            bus.ex_mem_write <= bus.id_mem_write;
            bus.ex_alu_ctrl  <= bus.id_alu_ctrl;
            bus.ex_rs        <= bus.id_rs;
            bus.ex_rt        <= bus.id_rt;
            bus.ex_dest      <= bus.id_dest;
            bus.ex_rd1       <= bus.id_rd1;
            bus.ex_rd2       <= bus.id_rd2;
            bus.ex_imm       <= bus.id_imm;
        end
    end

    // Saturating: a stuck stall condition must never wrap the count back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; register 0 is hardwired and never forwarded.
    always_comb begin
        bus.fwd_a_sel = 2'b00;
        bus.fwd_b_sel = 2'b00;
        if (bus.ex_valid) begin
            if (bus.exmem_reg_write && (bus.exmem_dest != '0) && (bus.exmem_dest == bus.ex_rs)) begin
                bus.fwd_a_sel = 2'b10;
            end else if (bus.memwb_reg_write && (bus.memwb_dest != '0) && (bus.memwb_dest == bus.ex_rs)) begin
                bus.fwd_a_sel = 2'b01;
            end
            if (bus.exmem_reg_write && (bus.exmem_dest != '0) && (bus.exmem_dest == bus.ex_rt)) begin
                bus.fwd_b_sel = 2'b10;
            end else if (bus.memwb_reg_write && (bus.memwb_dest != '0) && (bus.memwb_dest == bus.ex_rt)) begin
                bus.fwd_b_sel = 2'b01;
            end
        end
    end
endmodule
